// File: rtl/or_event_debounce_counter_pkg.sv
// ---------------------------------------------------------------------------
// or_event_debounce_counter_pkg
//
// Shared definitions for the OR-event debounce counter and its helpers.
//   - deb_state_e : debounce FSM state encoding (IDLE_LOW=0, CHECK_HIGH=1,
//                   STABLE_HIGH=2, CHECK_LOW=3). The numeric values are fixed
//                   so the debug state output decodes the same way everywhere.
//   - deb_cnt_width : width of the debounce sample counter for a given
//                   DEBOUNCE_CYCLES (clog2, never less than one bit).
// ---------------------------------------------------------------------------
package or_event_debounce_counter_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } deb_state_e;

    // The counter only ever holds 0 .. DEBOUNCE_CYCLES-1, so clog2 bits are
    // enough; the guard keeps a degenerate parameter from yielding width 0.
    function automatic int deb_cnt_width(input int cycles);
        if (cycles <= 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage : or_event_debounce_counter_pkg

// File: rtl/or_event_debounce_counter_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// One-bit two-flop synchroniser, reusable by other Logic_circuit blocks.
// The output is the input delayed by two rising edges of clk.
//
// Ports:
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  asynchronous active-low reset, both flops clear to 0
//   d      in  1  asynchronous input
//   q      out 1  synchronised output (second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule : sync_2ff

// File: rtl/or_event_debounce_counter.sv
// ---------------------------------------------------------------------------
// or_event_debounce_counter
//
// Consumes the 1-bit output of the three-input OR gate, synchronises it,
// debounces it into a committed level, emits one-cycle rise/fall pulses and
// keeps a saturating count of committed rising events.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronised samples needed to commit a
//                    level change (>= 2)
//   CNT_WIDTH        width of event_count
//
// Ports:
//   clk          in  1          system clock, rising edge
//   rst_n        in  1          asynchronous active-low reset
//   in_level     in  1          raw OR-gate output, may be async/glitchy
//   clr          in  1          synchronous clear of event_count and sat
//   level_out    out 1          debounced committed level
//   rise_pulse   out 1          one-cycle pulse on committed 0->1
//   fall_pulse   out 1          one-cycle pulse on committed 1->0
//   event_count  out CNT_WIDTH  saturating count of rise_pulse events
//   sat          out 1          high while event_count is all ones
//   dbg_state    out 2          current debounce FSM state (deb_state_e)
//
// Timing: with E0 the first edge that samples a new, steady in_level, the
// synchroniser presents it at E0+1, the FSM leaves its stable state at E0+2
// with cnt=1, and commits at E0+DEBOUNCE_CYCLES+1. The count follows one
// cycle after the rise pulse.
// ---------------------------------------------------------------------------
module or_event_debounce_counter
    import or_event_debounce_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_level,
    input  logic                 clr,
    output logic                 level_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic                 sat,
    output logic [1:0]           dbg_state
);

    localparam int                   DW       = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]        DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0]        DEB_ONE  = DW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic in_sync;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_level),
        .q     (in_sync)
    );

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    deb_state_e          state_q, state_d;
    logic [DW-1:0]       deb_cnt_q, deb_cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE_LOW;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                // The first high sample already counts as one.
                if (in_sync) begin
                    state_d   = CHECK_HIGH;
                    deb_cnt_d = DEB_ONE;
                end
            end

            CHECK_HIGH: begin
                if (!in_sync) begin
                    // Excursion too short: drop it without any visible effect.
                    state_d   = IDLE_LOW;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = STABLE_HIGH;
                    deb_cnt_d = '0;
                    level_d   = 1'b1;
                    rise_d    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end

            STABLE_HIGH: begin
                if (!in_sync) begin
                    state_d   = CHECK_LOW;
                    deb_cnt_d = DEB_ONE;
                end
            end

            CHECK_LOW: begin
                if (in_sync) begin
                    state_d   = STABLE_HIGH;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE_LOW;
                    deb_cnt_d = '0;
                    level_d   = 1'b0;
                    fall_d    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end

            default: begin
                state_d   = IDLE_LOW;
                deb_cnt_d = '0;
                level_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating event counter
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 sat_q, sat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            // A rise that lands in the same cycle as clr is dropped.
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            // Increment is driven by the registered pulse, so the count
            // moves one cycle after rise_pulse is visible.
            if (rise_q && (count_q != CNT_MAX)) begin
                count_d = count_q + CNT_ONE;
            end
            sat_d = (count_d == CNT_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign level_out   = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign event_count = count_q;
    assign sat         = sat_q;
    assign dbg_state   = state_q;

endmodule : or_event_debounce_counter

// File: tb/tb_or_event_debounce_counter.sv
module tb_or_event_debounce_counter;

  // ---------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------
  logic clk;
  logic rst_n;
  int unsigned cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------
  // DUTs: main (CNT_WIDTH=8) and saturation instance (CNT_WIDTH=4)
  // ---------------------------------------------------------------
  logic       in_level, clr;
  logic       level_out, rise_pulse, fall_pulse, sat;
  logic [7:0] event_count;
  logic [1:0] dbg_state;

  logic       in_s, clr_s;
  logic       level_s, rise_s, fall_s, sat_s;
  logic [3:0] count_s;
  logic [1:0] dbg_s;

  or_event_debounce_counter #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_level    (in_level),
    .clr         (clr),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .event_count (event_count),
    .sat         (sat),
    .dbg_state   (dbg_state)
  );

  or_event_debounce_counter #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(4)) u_dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_level    (in_s),
    .clr         (clr_s),
    .level_out   (level_s),
    .rise_pulse  (rise_s),
    .fall_pulse  (fall_s),
    .event_count (count_s),
    .sat         (sat_s),
    .dbg_state   (dbg_s)
  );

  // ---------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------
  typedef struct packed {
    logic        is_rise;
    logic [31:0] at_cyc;
    logic [7:0]  cnt;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic is_rise, input int unsigned at_cyc,
                          input logic [7:0] cnt, input logic s);
    exp_t e;
    e.is_rise = is_rise;
    e.at_cyc  = at_cyc;
    e.cnt     = cnt;
    e.sat     = s;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per pulse, checks the count a cycle later.
  logic       cnt_pending;
  logic [7:0] pend_cnt;
  logic       pend_sat;

  initial begin
    cnt_pending = 1'b0;
    pend_cnt    = '0;
    pend_sat    = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt_pending) begin
        check("event_count_after_pulse", event_count, pend_cnt);
        check("sat_after_pulse", sat, pend_sat);
        cnt_pending = 1'b0;
      end
      if (rise_pulse && fall_pulse) begin
        check("pulse_exclusive", {rise_pulse, fall_pulse}, 0);
      end
      if (rise_pulse || fall_pulse) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {rise_pulse, fall_pulse}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind_rise", rise_pulse, e.is_rise);
          check("pulse_cycle", cyc, e.at_cyc);
          check("level_with_pulse", level_out, e.is_rise);
          cnt_pending = 1'b1;
          pend_cnt    = e.cnt;
          pend_sat    = e.sat;
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic v);
    @(negedge clk);
    in_level = v;
  endtask

  // ---------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------
  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_level = 1'b1;
    clr      = 1'b0;
    in_s     = 1'b0;
    clr_s    = 1'b0;

    // 1. Reset held with in_level high: everything stays at zero.
    wait_neg(3);
    check("rst_level_out", level_out, 0);
    check("rst_rise_pulse", rise_pulse, 0);
    check("rst_fall_pulse", fall_pulse, 0);
    check("rst_event_count", event_count, 0);
    check("rst_sat", sat, 0);
    check("rst_state", dbg_state, 0);
    check("rst_sat_inst_count", count_s, 0);

    // Release: first sampling edge is cyc+1, commit at cyc+6.
    rst_n = 1'b1;
    push_exp(1'b1, cyc + 6, 8'd1, 1'b0);
    wait_neg(4);
    check("rise_not_early", level_out, 0);
    wait_neg(8);
    check("rise_level_held", level_out, 1);

    // 3. Fall from STABLE_HIGH; count unchanged.
    set_in(1'b0);
    push_exp(1'b0, cyc + 6, 8'd1, 1'b0);
    wait_neg(10);

    // 2. Glitch: three high samples, no commit.
    set_in(1'b1);
    wait_neg(3);
    in_level = 1'b0;
    wait_neg(10);
    check("glitch_level", level_out, 0);
    check("glitch_count", event_count, 1);

    // 5. clr in the cycle the increment would happen.
    set_in(1'b1);
    push_exp(1'b1, cyc + 6, 8'd0, 1'b0);
    wait_neg(6);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_neg(4);
    check("clr_level_kept", level_out, 1);
    set_in(1'b0);
    push_exp(1'b0, cyc + 6, 8'd0, 1'b0);
    wait_neg(10);
    set_in(1'b1);
    push_exp(1'b1, cyc + 6, 8'd1, 1'b0);
    wait_neg(10);

    // 6. Back to low, then reset while in CHECK_HIGH.
    set_in(1'b0);
    push_exp(1'b0, cyc + 6, 8'd1, 1'b0);
    wait_neg(10);
    set_in(1'b1);
    wait_neg(3);
    check("midchk_state_check_high", dbg_state, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_level_out", level_out, 0);
    check("midrst_rise_pulse", rise_pulse, 0);
    check("midrst_event_count", event_count, 0);
    check("midrst_sat", sat, 0);
    check("midrst_state", dbg_state, 0);
    wait_neg(2);
    rst_n = 1'b1;
    push_exp(1'b1, cyc + 6, 8'd1, 1'b0);
    wait_neg(12);

    // 4. Saturation on the 4-bit instance.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      in_s = 1'b1;
      wait_neg(8);
      in_s = 1'b0;
      wait_neg(8);
      check($sformatf("sat_count_round%0d", i), count_s, (i > 15) ? 15 : i);
      check($sformatf("sat_flag_round%0d", i), sat_s, (i >= 15) ? 1 : 0);
    end

    wait_neg(2);
    check("exp_q_drained", exp_q.size(), 0);
    check("cnt_check_drained", cnt_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_or_event_debounce_counter
